ysyx_22050710_mem_arbiter: RTL



---
 rtl/ysyx_22050710_mem_arbiter_pkg.sv | 18 +
 rtl/ysyx_22050710_rr_arb2.sv | 20 ++
 rtl/ysyx_22050710_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_mem_arbiter_pkg.sv
// Shared encodings for the IF/EX memory-port arbiter: FSM states and the
// requester (owner) indices used on the 2-bit request/grant vectors.
package ysyx_22050710_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_INST = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_e;

  localparam int OWN_INST = 0;
  localparam int OWN_DATA = 1;

  function automatic arb_state_e wait_state_for(input logic own_data);
    return own_data ? WAIT_DATA : WAIT_INST;
  endfunction

endpackage

// File: rtl/ysyx_22050710_rr_arb2.sv
// Combinational two-way round-robin picker. A lone request always wins; on a
// tie the requester that was not granted last wins. gnt is one-hot or zero.
module ysyx_22050710_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // bit 0 = fetch, bit 1 = data; last=1 means data won the previous round
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// Shares one SRAM-style memory port between instruction fetch and the EX data
// requester, one outstanding transaction at a time, responses routed to owner.
module ysyx_22050710_mem_arbiter
  import ysyx_22050710_mem_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_DATA_WD  = 64,
  parameter int SRAM_WMASK_WD = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_inst_req,
  input  logic [SRAM_ADDR_WD-1:0]  i_inst_addr,
  output logic                     o_inst_gnt,
  output logic                     o_inst_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_inst_rdata,
  input  logic                     i_data_req,
  input  logic                     i_data_wen,
  input  logic [SRAM_ADDR_WD-1:0]  i_data_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_data_wmask,
  input  logic [SRAM_DATA_WD-1:0]  i_data_wdata,
  output logic                     o_data_gnt,
  output logic                     o_data_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_data_rdata,
  output logic                     o_mem_req,
  output logic                     o_mem_wen,
  output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
  output logic [SRAM_WMASK_WD-1:0] o_mem_wmask,
  output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
  input  logic                     i_mem_gnt,
  input  logic                     i_mem_rvalid,
  input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata,
  output logic [1:0]               o_dbg_state
);

  // Handshake: a request transfers in the cycle where o_mem_req & i_mem_gnt;
  // the winner's *_gnt pulses in that same cycle and requesters hold their
  // request signals until then. Exactly one i_mem_rvalid answers each transfer.

  arb_state_e state_q, state_d;
  logic       last_data_q, last_data_d;
  logic [1:0] req, pick;
  logic       win_data;

  assign req[OWN_INST] = i_inst_req;
  assign req[OWN_DATA] = i_data_req;

  ysyx_22050710_rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_data_q),
    .gnt  (pick)
  );

  assign win_data    = pick[OWN_DATA];
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    o_mem_req     = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_addr    = '0;
    o_mem_wmask   = '0;
    o_mem_wdata   = '0;
    o_inst_gnt    = 1'b0;
    o_data_gnt    = 1'b0;
    o_inst_rvalid = 1'b0;
    o_inst_rdata  = '0;
    o_data_rvalid = 1'b0;
    o_data_rdata  = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          o_mem_req = 1'b1;
          if (win_data) begin
            o_mem_wen   = i_data_wen;
            o_mem_addr  = i_data_addr;
            o_mem_wmask = i_data_wmask;
            o_mem_wdata = i_data_wdata;
          end else begin
            o_mem_addr  = i_inst_addr;
          end
          if (i_mem_gnt) begin
            o_inst_gnt  = ~win_data;
            o_data_gnt  = win_data;
            state_d     = wait_state_for(win_data);
            last_data_d = win_data;
          end
        end
      end
      WAIT_INST: begin
        if (i_mem_rvalid) begin
          o_inst_rvalid = 1'b1;
          o_inst_rdata  = i_mem_rdata;
          state_d       = IDLE;
        end
      end
      WAIT_DATA: begin
        if (i_mem_rvalid) begin
          o_data_rvalid = 1'b1;
          o_data_rdata  = i_mem_rdata;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are combinational from requests, so hold them quiet in reset.
    if (i_rst) begin
      o_mem_req     = 1'b0;
      o_mem_wen     = 1'b0;
      o_mem_addr    = '0;
      o_mem_wmask   = '0;
      o_mem_wdata   = '0;
      o_inst_gnt    = 1'b0;
      o_data_gnt    = 1'b0;
      o_inst_rvalid = 1'b0;
      o_inst_rdata  = '0;
      o_data_rvalid = 1'b0;
      o_data_rdata  = '0;
    end
  end

endmodule
